mem_port_arbiter: RTL

Parametrised N-port arbiter that multiplexes the game's requesters (sequence generator, playback, user-input checker, ...) onto one single-port on-chip RAM. It replaces static user-select muxing with a per-cycle request/grant handshake, selectable round-robin or fixed-priority arbitration, and a read-return pipeline that routes RAM output back to the requester that issued the read. It sits between the control FSMs and the RAM instance.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: multiplexes NUM_PORTS requesters onto one single-port RAM.
// A combinational one-hot grant picks one requester per cycle (round-robin or
// fixed priority). The winner's access is registered onto the RAM pins. A
// shift pipeline carrying {valid, port index} steers the RAM read data back to
// the port that issued the read.
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int RR_MODE    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        wren_in,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata_in,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [DATA_W-1:0]           rdata,
  output logic [NUM_PORTS-1:0]        rvalid,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data,
  output logic                        mem_wren,
  input  logic [DATA_W-1:0]           mem_q
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  // One stage per cycle between the grant edge and the cycle mem_q is valid.
  localparam int DEPTH = RD_LATENCY + 1;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

  logic [IDX_W-1:0]  last_gnt_reg;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  int                cand;

  logic [DEPTH-1:0]  pipe_vld_reg;
  logic [IDX_W-1:0]  pipe_idx_reg [DEPTH];
  logic [NUM_PORTS-1:0] ret_onehot;

  // Unpack the flat per-port buses and decode the grant and return vectors.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_arr[gi]   = addr_in[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]  = wdata_in[gi*DATA_W +: DATA_W];
      assign gnt[gi]        = gnt_any && (gnt_idx == IDX_W'(gi));
      assign ret_onehot[gi] = pipe_vld_reg[DEPTH-1] &&
                              (pipe_idx_reg[DEPTH-1] == IDX_W'(gi));
    end
  endgenerate

  // Pick the winner: scan from last_gnt+1 (round-robin) or from port 0 (fixed).
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (RR_MODE != 0) begin
        cand = (int'(last_gnt_reg) + 1 + k) % NUM_PORTS;
      end else begin
        cand = k;
      end
      if (!gnt_any && req[cand[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Register the granted access onto the RAM pins and remember the winner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_address  <= '0;
      mem_data     <= '0;
      mem_wren     <= 1'b0;
      last_gnt_reg <= IDX_W'(NUM_PORTS - 1);
    end else begin
      mem_wren <= gnt_any && wren_in[gnt_idx];
      if (gnt_any) begin
        mem_address  <= addr_arr[gnt_idx];
        mem_data     <= wdata_arr[gnt_idx];
        last_gnt_reg <= gnt_idx;
      end
    end
  end

  // Track outstanding reads so each mem_q word is routed to its issuer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_vld_reg <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        pipe_idx_reg[k] <= '0;
      end
    end else begin
      pipe_vld_reg[0] <= gnt_any && !wren_in[gnt_idx];
      pipe_idx_reg[0] <= gnt_idx;
      for (int k = 1; k < DEPTH; k++) begin
        pipe_vld_reg[k] <= pipe_vld_reg[k-1];
        pipe_idx_reg[k] <= pipe_idx_reg[k-1];
      end
    end
  end

  // Capture returning read data; rdata holds between pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      rvalid <= ret_onehot;
      if (pipe_vld_reg[DEPTH-1]) begin
        rdata <= mem_q;
      end
    end
  end

endmodule
